// File: rtl/mc_cpu_core.sv
// mc_cpu_core: small multi-cycle CPU core with one shared memory port.
// Each instruction walks FETCH -> DECODE -> EXECUTE -> (MEMORY) -> WRITEBACK.
// Interrupts are taken only between instructions or from HALT.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   mem_addr/mem_wdata   byte address and store data of the current access
//   mem_rdata            fetch/load data, valid with mem_ready
//   mem_req/mem_we       access request and direction (1 = write)
//   mem_ready            completes the access in any cycle with mem_req=1
//   irq/irq_ack          level interrupt request, one-cycle entry pulse
//   halted               core parked in HALT
//   flags                {V,N,Z,C}
//   pc                   current program counter
module mc_cpu_core #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_8000,
    parameter logic [XLEN-1:0] IRQ_VEC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ready,
    input  logic            irq,
    output logic            irq_ack,
    output logic            halted,
    output logic [3:0]      flags,
    output logic [XLEN-1:0] pc
);
    localparam int AW = $clog2(NREG);

    localparam logic [4:0] OP_LOADI = 5'h01, OP_LOAD = 5'h02, OP_STORE = 5'h03,
                           OP_ADD   = 5'h04, OP_ADDI = 5'h05, OP_SUB   = 5'h06,
                           OP_SUBI  = 5'h07, OP_AND  = 5'h0B, OP_OR    = 5'h0C,
                           OP_XOR   = 5'h0D, OP_CMP  = 5'h10, OP_JMP   = 5'h11,
                           OP_JZ    = 5'h12, OP_JNZ  = 5'h13, OP_JC    = 5'h14,
                           OP_JNC   = 5'h15, OP_IRET = 5'h1E, OP_HALT  = 5'h1F;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_IRQ, S_HALT
    } state_t;

    state_t          state, state_nx;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc_q, epc, res, ea;
    logic [3:0]      flg;
    logic            ie, wen;
    logic [XLEN-1:0] rf [NREG];

    // Instruction fields
    logic [4:0]      op;
    logic [AW-1:0]   rd_a, rs1_a, rs2_a;
    logic [XLEN-1:0] rd_v, rs1_v, rs2_v, imm9, imm19, opb;

    assign op    = ir[31:27];
    assign rd_a  = ir[19 +: AW];
    assign rs1_a = ir[14 +: AW];
    assign rs2_a = ir[9 +: AW];
    assign rd_v  = rf[rd_a];
    assign rs1_v = rf[rs1_a];
    assign rs2_v = rf[rs2_a];
    assign imm9  = {{(XLEN-9){ir[8]}}, ir[8:0]};
    assign imm19 = XLEN'(ir[18:0]);
    assign opb   = (op == OP_ADDI || op == OP_SUBI) ? imm9 : rs2_v;

    logic unused_fields;
    assign unused_fields = ^ir[26:24];

    // ALU. The extra top bit of the subtract is the borrow (rs1 < opb unsigned).
    logic [XLEN:0]   add_w, sub_w;
    logic [XLEN-1:0] alu_res;
    logic            alu_c, alu_v, alu_upd, alu_wen, taken;

    assign add_w = {1'b0, rs1_v} + {1'b0, opb};
    assign sub_w = {1'b0, rs1_v} - {1'b0, opb};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_upd = 1'b0;
        alu_wen = 1'b0;
        case (op)
            OP_LOADI: begin alu_res = imm19; alu_wen = 1'b1; end
            OP_LOAD:  alu_wen = 1'b1;
            OP_ADD, OP_ADDI: begin
                alu_res = add_w[XLEN-1:0];
                alu_c   = add_w[XLEN];
                alu_v   = (rs1_v[XLEN-1] == opb[XLEN-1]) && (alu_res[XLEN-1] != rs1_v[XLEN-1]);
                alu_upd = 1'b1;
                alu_wen = 1'b1;
            end
            OP_SUB, OP_SUBI, OP_CMP: begin
                alu_res = sub_w[XLEN-1:0];
                alu_c   = sub_w[XLEN];
                alu_v   = (rs1_v[XLEN-1] != opb[XLEN-1]) && (alu_res[XLEN-1] != rs1_v[XLEN-1]);
                alu_upd = 1'b1;
                alu_wen = (op != OP_CMP);
            end
            OP_AND: begin alu_res = rs1_v & rs2_v; alu_upd = 1'b1; alu_wen = 1'b1; end
            OP_OR:  begin alu_res = rs1_v | rs2_v; alu_upd = 1'b1; alu_wen = 1'b1; end
            OP_XOR: begin alu_res = rs1_v ^ rs2_v; alu_upd = 1'b1; alu_wen = 1'b1; end
            default: ;
        endcase
    end

    // Branch conditions use the flags left by earlier instructions.
    always_comb begin
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = flg[1];
            OP_JNZ:  taken = !flg[1];
            OP_JC:   taken = flg[0];
            OP_JNC:  taken = !flg[0];
            default: taken = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    // Next state and memory-port outputs
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = '0;
        irq_ack   = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = rst_n;  // no request may be seen while reset is held
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                if (op == OP_LOAD || op == OP_STORE) state_nx = S_MEM;
                else if (op == OP_HALT)              state_nx = S_HALT;
                else                                 state_nx = S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = ea;
                if (op == OP_STORE) begin
                    mem_we    = 1'b1;
                    mem_wdata = rd_v;
                end
                if (mem_ready) state_nx = S_WB;
            end
            S_WB:   state_nx = (irq && ie) ? S_IRQ : S_FETCH;
            S_IRQ: begin
                irq_ack  = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (irq && ie) state_nx = S_IRQ;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir   <= '0;
            pc_q <= RESET_PC;
            epc  <= '0;
            res  <= '0;
            ea   <= '0;
            flg  <= '0;
            ie   <= 1'b1;
            wen  <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir   <= mem_rdata[31:0];
                    pc_q <= pc_q + XLEN'(4);
                end
                S_EXEC: begin
                    res <= alu_res;
                    wen <= alu_wen;
                    ea  <= rs1_v + imm9;
                    if (alu_upd) flg <= {alu_v, alu_res[XLEN-1], alu_res == '0, alu_c};
                    // pc already points past this instruction
                    if (taken) pc_q <= pc_q + (imm9 << 2);
                    if (op == OP_IRET) begin
                        pc_q <= epc;
                        ie   <= 1'b1;
                    end
                end
                S_MEM: if (mem_ready && op == OP_LOAD) res <= mem_rdata;
                S_WB:  if (wen && rd_a != '0) rf[rd_a] <= res;
                S_IRQ: begin
                    epc  <= pc_q;
                    ie   <= 1'b0;
                    pc_q <= IRQ_VEC;
                end
                default: ;
            endcase
        end
    end

    assign flags = flg;
    assign pc    = pc_q;
endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: small word memory model with optional
// store wait states, programs loaded per test, hand-computed expectations.
module tb_mc_cpu_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ready, irq, irq_ack, halted;
    logic [3:0]  flags;
    logic [31:0] pc;

    mc_cpu_core dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
        .irq(irq), .irq_ack(irq_ack), .halted(halted), .flags(flags), .pc(pc)
    );

    always #5 clk = ~clk;

    // Memory model: 4K words, index = addr[13:2]
    logic [31:0] mem [0:4095];
    int          store_waits = 0;
    logic        force_wait  = 1'b0;
    int          wait_cnt;
    int          st_cnt, ack_cnt;
    logic [31:0] st_addr, st_data;

    always_comb mem_rdata = mem[mem_addr[13:2]];
    always_comb mem_ready = !force_wait && !(mem_req && mem_we && wait_cnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= store_waits;
            st_cnt   <= 0;
            ack_cnt  <= 0;
            st_addr  <= '0;
            st_data  <= '0;
        end else begin
            if (mem_req && mem_we && wait_cnt != 0) wait_cnt <= wait_cnt - 1;
            if (mem_req && mem_we && mem_ready) begin
                st_cnt  <= st_cnt + 1;
                st_addr <= mem_addr;
                st_data <= mem_wdata;
            end
            if (irq_ack) ack_cnt <= ack_cnt + 1;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ins(input logic [4:0] op, input int rd, input int rs1,
                                        input int rs2, input int imm);
        logic [8:0] i9;
        i9 = imm[8:0];
        return {op, 3'b000, rd[4:0], rs1[4:0], rs2[4:0], i9};
    endfunction

    function automatic logic [31:0] loadi(input int rd, input int imm);
        return {5'h01, 3'b000, rd[4:0], imm[18:0]};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[13:2]] = w;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset with a cleared memory; caller loads a program then calls go().
    task automatic hold_reset();
        rst_n = 1'b0;
        irq   = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    endtask

    task automatic go();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int cnt;

        // Reset state and first LOADI
        store_waits = 0;
        hold_reset();
        put(32'h8000, loadi(1, 5));
        @(negedge clk); #1;
        chk("rst_mem_req",   mem_req, 0);
        chk("rst_mem_addr",  mem_addr, 32'h8000);
        chk("rst_pc",        pc, 32'h8000);
        chk("rst_misc",      {flags, halted, irq_ack, mem_we}, 0);
        chk("rst_wdata",     mem_wdata, 0);
        go();
        chk("fetch0_req",    {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h8000});
        tick(1);
        chk("fetch0_pc",     pc, 32'h8004);
        tick(2);
        chk("loadi_pre_wb",  dut.rf[1], 0);
        tick(1);
        chk("loadi_r1",      dut.rf[1], 5);
        chk("loadi_next",    {mem_req, mem_addr}, {1'b1, 32'h8004});

        // ADD with carry-out to zero
        hold_reset();
        put(32'h8000, ins(5'h07, 1, 0, 0, 1));   // SUBI R1,R0,1 -> FFFFFFFF
        put(32'h8004, loadi(2, 1));
        put(32'h8008, ins(5'h04, 3, 1, 2, 0));   // ADD R3,R1,R2
        put(32'h800C, ins(5'h1F, 0, 0, 0, 0));   // HALT
        go();
        tick(4);
        chk("subi_r1",       dut.rf[1], 32'hFFFF_FFFF);
        chk("subi_flags",    flags, 4'b0101);     // borrow, negative
        tick(8);
        chk("add_r3",        dut.rf[3], 0);
        chk("add_flags",     flags, 4'b0011);     // V=0 N=0 Z=1 C=1
        tick(3);
        chk("halt_state",    {halted, mem_req, pc}, {1'b1, 1'b0, 32'h8010});

        // STORE with three wait states
        hold_reset();
        store_waits = 3;
        put(32'h8000, loadi(1, 32'h1234));
        put(32'h8004, loadi(2, 32'h100));
        put(32'h8008, ins(5'h03, 1, 2, 0, 8));   // STORE R1,[R2+8]
        put(32'h800C, ins(5'h1F, 0, 0, 0, 0));
        go();
        tick(8);
        chk("st_fetch",      mem_addr, 32'h8008);
        tick(3);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("st_hold%0d", k), {mem_req, mem_we, mem_addr, mem_wdata},
                {1'b1, 1'b1, 32'h108, 32'h1234});
            tick(1);
        end
        tick(1);
        chk("st_8cyc",       {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h800C});
        chk("st_written",    {st_cnt[7:0], st_addr, st_data}, {8'd1, 32'h108, 32'h1234});
        store_waits = 0;

        // CMP then JZ back / JNZ through
        hold_reset();
        put(32'h8000, ins(5'h10, 0, 1, 1, 0));   // CMP R1,R1
        put(32'h8004, ins(5'h12, 0, 0, 0, -2));  // JZ -2
        go();
        tick(8);
        chk("jz_pc",         pc, 32'h8000);
        chk("cmp_flags",     flags, 4'b0010);
        hold_reset();
        put(32'h8000, ins(5'h10, 0, 1, 1, 0));
        put(32'h8004, ins(5'h13, 0, 0, 0, -2));  // JNZ -2
        put(32'h8008, ins(5'h1F, 0, 0, 0, 0));
        go();
        tick(8);
        chk("jnz_pc",        {pc, mem_addr}, {32'h8008, 32'h8008});

        // Interrupt during ADD, masked re-request, IRET
        hold_reset();
        put(32'h8000, loadi(1, 7));
        put(32'h8004, loadi(2, 3));
        put(32'h8010, ins(5'h04, 3, 1, 2, 0));
        put(32'h8014, ins(5'h1F, 0, 0, 0, 0));
        put(32'h0108, ins(5'h1E, 0, 0, 0, 0));   // NOP, NOP, IRET at 0x100
        go();
        tick(16);
        chk("irq_at_add",    mem_addr, 32'h8010);
        irq = 1'b1;
        tick(3);
        chk("irq_no_abort",  irq_ack, 0);
        tick(1);
        chk("irq_ack_pulse", irq_ack, 1);
        chk("irq_add_done",  dut.rf[3], 10);
        tick(1);
        chk("irq_vec",       {irq_ack, pc, mem_addr}, {1'b0, 32'h100, 32'h100});
        chk("irq_epc",       dut.epc, 32'h8014);
        tick(4);
        chk("irq_masked",    {irq_ack, pc}, {1'b0, 32'h104});
        irq = 1'b0;
        tick(8);
        chk("iret_pc",       {pc, mem_addr}, {32'h8014, 32'h8014});
        chk("irq_ack_once",  ack_cnt, 1);

        // HALT, then wake on interrupt
        hold_reset();
        put(32'h8020, ins(5'h1F, 0, 0, 0, 0));
        put(32'h0100, ins(5'h1F, 0, 0, 0, 0));
        go();
        tick(35);
        chk("halt_at",       {halted, pc}, {1'b1, 32'h8024});
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            cnt += int'(mem_req);
        end
        chk("halt_no_req",   cnt, 0);
        irq = 1'b1;
        tick(1);
        chk("halt_wake",     {halted, irq_ack}, {1'b0, 1'b1});
        tick(1);
        irq = 1'b0;
        chk("halt_vec",      {mem_req, mem_addr}, {1'b1, 32'h100});
        chk("halt_epc",      dut.epc, 32'h8024);

        // Reset asserted during a stalled fetch
        hold_reset();
        force_wait = 1'b1;
        put(32'h8000, loadi(1, 5));
        go();
        tick(3);
        chk("stall_fetch",   {mem_req, pc}, {1'b1, 32'h8000});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req",   {mem_req, mem_addr}, {1'b0, 32'h8000});
        force_wait = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mc_cpu_core.md
MC_CPU_CORE -- requirements
Module: mc_cpu_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (16..64).
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, 8..32); register fields use the low log2(NREG) bits.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_8000, first fetch address.
REQ-004 SHALL have parameter IRQ_VEC, default 32'h0000_0100, interrupt entry address.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 mem_addr  out  XLEN  byte address of the current access.
REQ-008 mem_wdata  out  XLEN  store data.
REQ-009 mem_rdata  in  XLEN  fetch/load data, valid when mem_ready=1.
REQ-010 mem_req  out  1  access request.
REQ-011 mem_we  out  1  1=write, 0=read; meaningful only with mem_req.
REQ-012 mem_ready  in  1  access completes in any cycle where mem_req=1 and mem_ready=1.
REQ-013 irq  in  1  level interrupt request.
REQ-014 irq_ack  out  1  one-cycle pulse on interrupt entry.
REQ-015 halted  out  1  core stopped.
REQ-016 flags  out  4  {V,N,Z,C}.
REQ-017 pc  out  XLEN  current program counter.

Function
REQ-018 Instruction word SHALL be 32 bits: op[31:27], rd[23:19], rs1[18:14], rs2[13:9], imm9[8:0] sign-extended, imm19[18:0] zero-extended.
REQ-019 States SHALL be FETCH->DECODE->EXECUTE->(MEMORY if LOAD/STORE)->WRITEBACK->FETCH, plus IRQ and HALT.
REQ-020 mem_req SHALL be 1 only in FETCH and MEMORY; mem_addr/mem_we/mem_wdata stable while mem_req=1 and mem_ready=0; state holds until mem_ready.
REQ-021 FETCH completion SHALL latch mem_rdata as instruction and set pc <= pc+4 (mod 2^XLEN).
REQ-022 Zero-wait latency SHALL be 4 cycles per instruction, 5 for LOAD/STORE; each wait cycle adds 1.
REQ-023 R0 SHALL read 0; writes to R0 discarded; register writes occur only in WRITEBACK.
REQ-024 Opcodes: 00 NOP; 01 LOADI rd=imm19; 02 LOAD rd=mem[rs1+imm9]; 03 STORE mem[rs1+imm9]=rd; 04 ADD; 05 ADDI rd=rs1+imm9; 06 SUB; 07 SUBI; 0B AND; 0C OR; 0D XOR; 10 CMP (rs1-rs2, flags only); 11 JMP; 12 JZ; 13 JNZ; 14 JC; 15 JNC; 1E IRET; 1F HALT; all others execute as NOP.
REQ-025 Arithmetic SHALL be XLEN-bit modulo; ADD C=carry-out; SUB/SUBI/CMP C=borrow (rs1<operand unsigned); V=signed overflow; Z,N from result; AND/OR/XOR clear C,V.
REQ-026 Flags SHALL update in EXECUTE only for 04,05,06,07,0B,0C,0D,10.
REQ-027 Taken branch SHALL set pc <= (fetched pc+4) + (sext(imm9)<<2) in EXECUTE; not-taken leaves pc unchanged.
REQ-028 Internal ie bit SHALL gate interrupts; on WRITEBACK exit with irq=1 and ie=1, go to IRQ for 1 cycle: epc<=pc, ie<=0, pc<=IRQ_VEC, irq_ack=1, then FETCH.
REQ-029 IRET SHALL set pc<=epc and ie<=1 in EXECUTE.
REQ-030 HALT SHALL enter HALT with halted=1, no memory requests; irq=1 with ie=1 SHALL exit via IRQ (epc = address after HALT), halted cleared.
REQ-031 irq asserted mid-instruction SHALL not abort it; sampled only at WRITEBACK exit or in HALT.

Reset
REQ-032 rst_n low SHALL immediately set state=FETCH, pc=RESET_PC, flags=0, ie=1, epc=0, halted=0, irq_ack=0, mem_req=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0, all registers 0, including assertion mid-access with no completion.

Verification
REQ-033 Reset release, mem_ready=1, LOADI R1,5 at 0x8000 -> mem_req at 0x8000 first cycle, R1=5 after 4 cycles, pc=0x8004.
REQ-034 R1=0xFFFFFFFF, R2=1, ADD R3,R1,R2 -> R3=0, flags C=1,Z=1,N=0,V=0.
REQ-035 STORE R1 to [R2+8], R2=0x100, mem_ready low 3 cycles -> mem_addr=0x108, mem_we=1, mem_wdata stable 4 cycles, instruction takes 8 cycles.
REQ-036 CMP R1,R1 then JZ imm9=-2 at 0x8004 -> pc=0x8000; JNZ same position -> pc=0x8008.
REQ-037 irq=1 during ADD at 0x8010 -> ADD completes, irq_ack pulse, pc=0x100, epc=0x8014; IRET -> pc=0x8014; second irq during handler ignored.
REQ-038 HALT at 0x8020 -> halted=1, mem_req=0 indefinitely; irq=1 -> halted=0, fetch at 0x100, epc=0x8024.
